// File: rtl/button_event_pkg.sv
// Shared types and defaults for the button event generator.
// Holds the FSM state encoding and the default timing constants.
// Imported by button_event and usable by other control-input blocks.
package button_event_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_t;

  localparam int BTN_LONG_CYCLES_DEF   = 8;
  localparam int BTN_REPEAT_CYCLES_DEF = 4;
  localparam int BTN_CNT_W_DEF         = 16;
  localparam int BTN_PRESS_CNT_W       = 8;

endpackage

// File: rtl/button_event_edge_detect.sv
// edge_detect: one-cycle rise/fall strobes for a level already synchronous to clk.
// Latency: rise/fall are combinational against the previous registered sample.
// No backpressure; samples the input every cycle.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic prev_q;

  // Previous-cycle sample; cleared by reset so a level high across reset reads as a rise.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= din;
  end

  assign rise = din & ~prev_q;
  assign fall = ~din & prev_q;

endmodule

// File: rtl/button_event.sv
// button_event: debounced level -> press/release/long/repeat pulses, held level, press count.
// Latency: every output is registered one edge after the sampled input change.
// No backpressure. Optional auto-repeat enabled by macro BUTTON_EVENT_REPEAT_EN.
module button_event
  import button_event_pkg::*;
#(
  parameter int LONG_CYCLES   = BTN_LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES = BTN_REPEAT_CYCLES_DEF,
  parameter int CNT_W         = BTN_CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btn_in,
  output logic                       press_pulse,
  output logic                       release_pulse,
  output logic                       long_pulse,
  output logic                       repeat_pulse,
  output logic                       held,
  output logic [BTN_PRESS_CNT_W-1:0] press_count
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_t                 state, state_n;
  logic [CNT_W-1:0]           timer, timer_n;
  logic                       rise, fall;
  logic                       press_n, release_n, long_n, held_n;
  logic [BTN_PRESS_CNT_W-1:0] count_n;

  edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_in),
    .rise (rise),
    .fall (fall)
  );

`ifdef BUTTON_EVENT_REPEAT_EN
  logic repeat_n;
`else
  // Repeat hardware is absent; keep the reload constant referenced for lint.
  logic unused_rep_last;
  assign unused_rep_last = ^REP_LAST;
  assign repeat_pulse    = 1'b0;
`endif

  // Next-state, timer and output-pulse decode; a fall always wins over a timer expiry.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    press_n   = 1'b0;
    release_n = 1'b0;
    long_n    = 1'b0;
    count_n   = press_count;
`ifdef BUTTON_EVENT_REPEAT_EN
    repeat_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rise) begin
          state_n = PRESSED;
          timer_n = '0;
          press_n = 1'b1;
          count_n = press_count + 1'b1;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_n   = IDLE;
          release_n = 1'b1;
        end else if (timer == LONG_LAST) begin
          state_n = HELD;
          long_n  = 1'b1;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      HELD: begin
        if (fall) begin
          state_n   = IDLE;
          release_n = 1'b1;
        end
`ifdef BUTTON_EVENT_REPEAT_EN
        else if (timer == REP_LAST) begin
          repeat_n = 1'b1;
          timer_n  = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
`else
        else begin
          timer_n = '0;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
    held_n = (state_n != IDLE);
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      held          <= 1'b0;
      press_count   <= '0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      long_pulse    <= long_n;
      held          <= held_n;
      press_count   <= count_n;
    end
  end

`ifdef BUTTON_EVENT_REPEAT_EN
  // Auto-repeat strobe register.
  always_ff @(posedge clk) begin
    if (rst) repeat_pulse <= 1'b0;
    else     repeat_pulse <= repeat_n;
  end
`endif

endmodule

// File: doc/button_event.md
# button_event

Press-event generator sitting directly downstream of the debouncer's clean output. Converts a debounced button level into single-cycle event pulses (press, release, long-press, auto-repeat) plus a held level and a press counter. Its outputs drive the operand-entry/control logic of the dot-product datapath, so every physical press yields exactly one `press_pulse` regardless of hold time.

## Interface
- `LONG_CYCLES`, default 8: cycles from `press_pulse` to `long_pulse` while held; legal range 2 to 2^CNT_W-1.
- `REPEAT_CYCLES`, default 4: auto-repeat period after `long_pulse`; legal range 2 to 2^CNT_W-1.
- `CNT_W`, default 16: hold-timer width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_in` in 1: debounced button level, already synchronous to `clk`.
- `press_pulse` out 1: one-cycle pulse on press.
- `release_pulse` out 1: one-cycle pulse on release.
- `long_pulse` out 1: one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `repeat_pulse` out 1: one-cycle auto-repeat pulse (see Configuration).
- `held` out 1: level, high while a press is in progress.
- `press_count` out 8: number of presses since reset.

## Operation
- All outputs are registered. Reset value of every output is 0; after reset the FSM is IDLE, `prev_q`=0 and the timer is 0.
- `prev_q` registers `btn_in` every cycle. A rise is `btn_in & ~prev_q`; a fall is `~btn_in & prev_q`.
- FSM states:
  - IDLE: on rise, go to PRESSED, clear the timer, assert `press_pulse` and `held`, and increment `press_count`.
  - PRESSED: the timer increments each cycle.
    - On fall, go to IDLE and assert `release_pulse`.
    - When the timer reaches `LONG_CYCLES`-1, go to HELD, assert `long_pulse` and clear the timer.
  - HELD:
    - On fall, go to IDLE and assert `release_pulse`.
    - Otherwise the timer behaviour depends on Configuration.
- `held`=1 in PRESSED and HELD. It drops in the same cycle `release_pulse` is high.
- A fall takes priority over a timer expiry in the same cycle: `release_pulse` only, with no `long_pulse` or `repeat_pulse`.
- `press_count` wraps from 255 to 0 without saturating.
- `btn_in` high across reset deassertion: with `prev_q`=0, the first sampled high counts as a rise, so `press_pulse` fires once.
- Reset mid-press returns to IDLE. No `release_pulse` is emitted for the aborted press.
- At most one of `press_pulse`, `release_pulse`, `long_pulse`, `repeat_pulse` is high in any cycle.

## Timing
- Let `btn_in` first be sampled high at edge k. Then `press_pulse`=1 during cycle k+1, i.e. it is registered at edge k.
- `long_pulse` is high exactly `LONG_CYCLES` cycles after the `press_pulse` cycle.
- Repeat pulses occur at `long_pulse` + n·`REPEAT_CYCLES`, for n ≥ 1.
- Let `btn_in` first be sampled low at edge m. Then `release_pulse`=1 during cycle m+1.
- The minimum press is one cycle high, which produces `press_pulse` followed by `release_pulse` in the next cycle.

## Configuration
- Macro `BUTTON_EVENT_REPEAT_EN`.
- Defined: in HELD the timer counts. At `REPEAT_CYCLES`-1 it asserts `repeat_pulse` and clears, and this repeats until release.
- Undefined: the repeat logic is removed. In HELD the timer is held at 0 and `repeat_pulse` is tied to 0. All other behaviour is unchanged.

## Structure
- Package `button_event_pkg` holds:
  - the state typedef `btn_state_t` (IDLE, PRESSED, HELD);
  - default constants `BTN_LONG_CYCLES_DEF`=8, `BTN_REPEAT_CYCLES_DEF`=4, `BTN_CNT_W_DEF`=16;
  - `BTN_PRESS_CNT_W`=8.
- One natural sub-module, `edge_detect`. It contains `prev_q` and outputs `rise` and `fall`, and is reusable by other control inputs.

## Test plan
All scenarios use the defaults `LONG_CYCLES`=8, `REPEAT_CYCLES`=4.
- Reset while `btn_in`=0, then a 3-cycle high pulse. Expect `press_pulse` at cycle +1, `held`=1 for 3 cycles, `release_pulse` once, `press_count`=1, no `long_pulse`.
- Hold for 20 cycles with REPEAT_EN defined:
  - `long_pulse` 8 cycles after `press_pulse`;
  - `repeat_pulse` at +12 and +16 (and +20 if still held);
  - one `release_pulse`.
- Same 20-cycle hold with REPEAT_EN undefined. Expect `long_pulse` at +8, `repeat_pulse` never high, one `release_pulse`.
- Release on the exact expiry cycle (hold 8 cycles). Expect `release_pulse` only, no `long_pulse`, FSM back in IDLE.
- 256 one-cycle presses separated by one low cycle. Expect `press_count` to wrap to 0, with 256 `press_pulse` and 256 `release_pulse`.
- Assert `rst` mid-hold at cycle +5 with `btn_in` still high:
  - outputs 0 during reset and no `release_pulse`;
  - one new `press_pulse` after deassertion;
  - `press_count`=1.
